uart_rx: RTL

- UART receiver that deserialises 8N1 or 8E1 frames from a 1-bit serial line into bytes.
- Counterpart of the serial transmit path leaving riscv_top on Tx. It is instantiated in simulation benches as the host-side console model, and on-chip as the receive side feeding the CPU's I/O bus.
- Presents each received byte through a one-entry holding register with a valid/ready handshake.
- Reports framing, parity and overrun errors.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1/8E1 deserialiser with a one-entry holding register.
// Reports framing, parity and sticky overrun errors.
module uart_rx #(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    // IDLE spends one cycle detecting the edge, so START waits one less
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bad_q, par_bad_d;
    logic             done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             overrun_q, overrun_d;
    logic             rx_s;
    logic             bit_end;

    assign rx_s    = sync_q[1];
    assign sync_d  = {sync_q[0], rx};
    assign bit_end = (cnt_q == BIT_END);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        done_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == 3'd7)
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rx_s;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: a completing byte wins over a same-cycle accept
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (done_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ready) overrun_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            done_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            done_q       <= done_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
